button_reader: RTL and testbench
================================

Name: button_reader

Overview:
- Input-side counterpart to the LED blink counter: reads WIDTH raw push-button/switch lines and synchronises each line.
- Debounces each line with a per-channel counter and FSM.
- Reports stable levels, one-cycle press/release pulses, and a valid/ready press-event stream carrying the channel index.
- Sits between board pins and control logic, e.g. LED pattern select or counter step.

Parameters:
- WIDTH, 8, number of button channels (>=2).
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2).
- DEBOUNCE_CYCLES, 1024, consecutive cycles a new level must persist before it is accepted (>=2).
- HOLD_CYCLES, 65536, stable-high cycles before HOLD asserts (optional feature only).
- IDX_W, $clog2(WIDTH), width of the event channel index.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset, synchronous, active-high.
- BTN  input  WIDTH  raw asynchronous button levels, 1 = pressed.
- STATE  output  WIDTH  debounced level per channel.
- PRESS  output  WIDTH  one-cycle pulse on debounced 0->1.
- RELEASE  output  WIDTH  one-cycle pulse on debounced 1->0.
- EVT_VALID  output  1  press event available.
- EVT_READY  input  1  consumer accepts the event.
- EVT_IDX  output  IDX_W  channel index of the presented event.
- OVERFLOW  output  1  sticky; a press was lost.
- HOLD  output  WIDTH  long-press level (see Optional Feature).

Behaviour:
- Interface: one clock CLK; RST is synchronous and active-high. All outputs are registered.
- Reset values: STATE, PRESS, RELEASE, HOLD, EVT_VALID, EVT_IDX and OVERFLOW are 0. Synchroniser flops, counters and pending bits are cleared.
- Reset mid-debounce discards the partial count and any pending events. BTN held high through reset is re-debounced as a fresh press after reset.
- Per-channel FSM states:
  - LOW_STABLE: sync == 0 stays; sync == 1 -> RISE_WAIT, cnt <= 1.
  - RISE_WAIT: sync == 0 -> LOW_STABLE, cnt <= 0 (glitch rejected).
    - sync == 1 and cnt == DEBOUNCE_CYCLES-1 -> HIGH_STABLE, STATE <= 1, PRESS pulse, cnt <= 0.
    - otherwise cnt++.
  - HIGH_STABLE / FALL_WAIT: mirror image, producing RELEASE.
- Counter width is $clog2(DEBOUNCE_CYCLES)+1; it never wraps.
- Latency: BTN edge -> STATE/PRESS = SYNC_STAGES + DEBOUNCE_CYCLES cycles, provided BTN is held stable.
- A pulse shorter than DEBOUNCE_CYCLES sync cycles produces no output change.
- Pending register: PRESS[i] sets pend[i] on the next edge.
- Event register:
  - When EVT_VALID == 0, or on the accepting cycle (EVT_VALID && EVT_READY), load the lowest-index pend bit, excluding the channel being accepted.
  - EVT_VALID asserts the edge after pend is set, so PRESS -> EVT_VALID takes 2 cycles minimum.
  - An accepted channel's pend bit clears in the same cycle.
  - EVT_VALID/EVT_IDX hold stable while EVT_READY == 0.
  - EVT_READY held high drains one event per cycle.
- Simultaneous set and clear of the same pend bit: set wins, so the event is re-presented later. OVERFLOW is not set.
- New PRESS on a channel whose pend bit is set and not being cleared: the event is dropped and OVERFLOW <= 1 until RST.
- Several channels pressing in the same cycle are all captured and emitted in ascending index order.

Optional Feature:
- Macro: BUTTON_READER_HOLD_EN.
- Defined:
  - A per-channel hold counter runs while HIGH_STABLE.
  - HOLD[i] <= 1 after HOLD_CYCLES consecutive stable-high cycles.
  - HOLD[i] clears in the same cycle as RELEASE[i].
  - The hold counter saturates and never wraps.
- Undefined: HOLD is tied to 0, no hold counters are synthesised, and the port remains present.

Decomposition:
- Shared package button_reader_pkg holds:
  - FSM state encoding: LOW_STABLE, RISE_WAIT, HIGH_STABLE, FALL_WAIT.
  - Localparam helpers for counter widths.
- Sub-module button_debounce_cell: one channel containing synchroniser, FSM, counter, PRESS/RELEASE pulses and optional hold counter. It is instantiated WIDTH times in a generate loop.
- The top level owns the pending bits, priority select, event register and OVERFLOW.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
1. BTN[0] 0->1 held -> STATE[0]=1 and PRESS[0] pulse exactly 6 cycles after the edge. EVT_VALID=1 with EVT_IDX=0 two cycles later. With EVT_READY=1, EVT_VALID drops the next cycle.
2. BTN[1] high for 3 cycles then low -> no PRESS, STATE[1] stays 0, EVT_VALID stays 0.
3. BTN=4'b1010 in one cycle, EVT_READY=0 for 20 cycles, then 1 -> EVT_IDX=1 is presented held stable, then EVT_IDX=3, then EVT_VALID=0. OVERFLOW=0.
4. EVT_READY=0; channel 2 pressed, released and pressed again -> second PRESS[2] is dropped, OVERFLOW=1 and sticky. Only one event for index 2 is emitted.
5. RST asserted for 1 cycle at cnt=2 during RISE_WAIT on channel 0 -> all outputs 0 the next cycle. With BTN[0] still high, PRESS[0] fires 6 cycles after RST deasserts.
6. With BUTTON_READER_HOLD_EN: hold BTN[3] -> HOLD[3]=1 eight cycles after STATE[3]=1, and HOLD[3]=0 together with RELEASE[3]. Without the macro: HOLD stays 0 throughout.

Source files
------------

// File: rtl/button_reader_pkg.sv
// Shared definitions for the button_reader block: debounce FSM encoding
// and the helper used to size the debounce and hold counters.
`timescale 1ns/1ps

package button_reader_pkg;

  // Per-channel debounce states. The two *_WAIT states count how long a
  // new level has persisted before it is accepted.
  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_WAIT   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_WAIT   = 2'd3
  } db_state_t;

  // Counter width able to hold a terminal count of (cycles-1) with one
  // spare bit of headroom, so the counters never wrap.
  function automatic int cnt_w(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/button_reader_if.sv
// Press-event stream: valid/ready handshake carrying the channel index of
// a debounced button press.
`timescale 1ns/1ps

interface button_reader_if #(
  parameter int IDX_W = 3
);
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;

  // Producer side: the button reader presents events.
  modport master (
    output evt_valid,
    output evt_idx,
    input  evt_ready
  );

  // Consumer side: control logic accepts events.
  modport slave (
    input  evt_valid,
    input  evt_idx,
    output evt_ready
  );
endinterface

// File: rtl/button_debounce_cell.sv
// One button channel: synchroniser, debounce FSM with persistence counter,
// registered level plus press/release pulses. When BUTTON_READER_HOLD_EN is
// defined a saturating hold counter drives a long-press level; otherwise the
// hold output is tied low and no hold counter exists.
`timescale 1ns/1ps

module button_debounce_cell
  import button_reader_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic state,
  output logic press,
  output logic release_pulse,
  output logic hold
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  db_state_t        fsm, fsm_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             state_next;
  logic             press_next;
  logic             release_next;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce state, persistence counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm           <= LOW_STABLE;
      cnt           <= '0;
      state         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      fsm           <= fsm_next;
      cnt           <= cnt_next;
      state         <= state_next;
      press         <= press_next;
      release_pulse <= release_next;
    end
  end

  // Next-state logic: a new level must persist DEBOUNCE_CYCLES sync cycles;
  // any return to the old level restarts from the stable state.
  always_comb begin
    fsm_next     = fsm;
    cnt_next     = cnt;
    state_next   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (fsm)
      LOW_STABLE: begin
        if (sync) begin
          fsm_next = RISE_WAIT;
          cnt_next = CNT_W'(1);
        end
      end
      RISE_WAIT: begin
        if (!sync) begin
          fsm_next = LOW_STABLE;
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          fsm_next   = HIGH_STABLE;
          state_next = 1'b1;
          press_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!sync) begin
          fsm_next = FALL_WAIT;
          cnt_next = CNT_W'(1);
        end
      end
      FALL_WAIT: begin
        if (sync) begin
          fsm_next = HIGH_STABLE;
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          fsm_next     = LOW_STABLE;
          state_next   = 1'b0;
          release_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        fsm_next = LOW_STABLE;
        cnt_next = '0;
      end
    endcase
  end

`ifdef BUTTON_READER_HOLD_EN
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_q;

  // Count consecutive HIGH_STABLE cycles; saturate at the terminal count and
  // keep the long-press level until the debounced release.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      hold_q   <= 1'b0;
    end else if (release_next) begin
      hold_cnt <= '0;
      hold_q   <= 1'b0;
    end else if (fsm == HIGH_STABLE) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_q <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end else begin
      hold_cnt <= '0;
    end
  end

  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// Top level of the button reader: WIDTH debounce cells plus the pending
// bits, lowest-index priority select, press-event register and sticky
// OVERFLOW flag. Long-press HOLD outputs are produced only when
// BUTTON_READER_HOLD_EN is defined; otherwise HOLD reads as zero.
`timescale 1ns/1ps

module button_reader
  import button_reader_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 65536,
  parameter int IDX_W           = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   btn,
  output logic [WIDTH-1:0]   state,
  output logic [WIDTH-1:0]   press,
  output logic [WIDTH-1:0]   release_pulse,
  output logic [WIDTH-1:0]   hold,
  output logic               overflow,
  button_reader_if.master    evt
);

  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_next;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] cand;
  logic             accept;
  logic             lost;
  logic             evt_valid_q;
  logic [IDX_W-1:0] evt_idx_q;

  // Lowest set bit of v; zero when v is empty (valid is driven separately).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    button_debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .btn           (btn[g]),
      .state         (state[g]),
      .press         (press[g]),
      .release_pulse (release_pulse[g]),
      .hold          (hold[g])
    );
  end

  assign accept = evt_valid_q & evt.evt_ready;

  // Pending-bit bookkeeping: the accepted channel is cleared, a new press
  // sets its bit (set beats clear), and a press landing on a still-pending
  // bit is a lost event.
  always_comb begin
    clr       = '0;
    if (accept) clr = WIDTH'(1) << evt_idx_q;
    cand      = pend & ~clr;
    pend_next = cand | press;
    lost      = |(press & cand);
  end

  // Pending bits, event register and sticky overflow. The event register
  // reloads when empty or on the accepting cycle, so a held-high ready
  // drains one event per cycle and a low ready freezes valid/index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
      overflow    <= 1'b0;
    end else begin
      pend <= pend_next;
      if (lost) overflow <= 1'b1;
      if (!evt_valid_q || accept) begin
        evt_valid_q <= |cand;
        evt_idx_q   <= lowest_idx(cand);
      end
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_idx   = evt_idx_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader (WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=8). Expected presses (channel and cycle)
// and expected events (channel index) are queued when stimulus is applied;
// a monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps

module tb_button_reader;

  localparam int W = 4;

  typedef struct {
    int ch;
    int cyc;
  } press_exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn;
  logic [W-1:0] st;
  logic [W-1:0] press;
  logic [W-1:0] rel;
  logic [W-1:0] hold;
  logic         overflow;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int c;

  press_exp_t press_q[$];
  int         evt_q[$];

  button_reader_if #(.IDX_W(2)) evt_if ();

  button_reader #(
    .WIDTH           (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8),
    .IDX_W           (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .state         (st),
    .press         (press),
    .release_pulse (rel),
    .hold          (hold),
    .overflow      (overflow),
    .evt           (evt_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  // Scoreboard monitor: compare every press pulse and every accepted event
  // against the queued expectations.
  always @(negedge clk) begin : monitor
    press_exp_t pe;
    int ei;
    for (int i = 0; i < W; i++) begin
      if (press[i]) begin
        if (press_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL press_unexpected at cycle %0d: got channel %0d expected none", cyc, i);
        end else begin
          pe = press_q.pop_front();
          check("press_ch", i, pe.ch);
          check("press_cyc", cyc, pe.cyc);
        end
      end
    end
    if (evt_if.evt_valid && evt_if.evt_ready) begin
      if (evt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected at cycle %0d: got idx %0d expected none", cyc, evt_if.evt_idx);
      end else begin
        ei = evt_q.pop_front();
        check("evt_idx", evt_if.evt_idx, ei);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    btn = '0;
    evt_if.evt_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    to_cyc(cyc);
    check("rst_state", st, 0);
    check("rst_press", press, 0);
    check("rst_release", rel, 0);
    check("rst_hold", hold, 0);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_idx", evt_if.evt_idx, 0);
    check("rst_overflow", overflow, 0);

    // 1: single press, latency and one-cycle event drain
    step();
    evt_if.evt_ready = 1'b1;
    btn[0] = 1'b1;
    c = cyc;
    press_q.push_back('{0, c + 6});
    evt_q.push_back(0);
    to_cyc(c + 5); check("t1_state_early", st[0], 0);
    to_cyc(c + 6); check("t1_state", st[0], 1);
    to_cyc(c + 7); check("t1_valid_early", evt_if.evt_valid, 0);
    to_cyc(c + 8); check("t1_valid", evt_if.evt_valid, 1);
    check("t1_idx", evt_if.evt_idx, 0);
    to_cyc(c + 9); check("t1_valid_drop", evt_if.evt_valid, 0);
    step();
    btn[0] = 1'b0;
    c = cyc;
    to_cyc(c + 5); check("t1_rel_early", rel[0], 0);
    check("t1_state_hi", st[0], 1);
    to_cyc(c + 6); check("t1_rel", rel[0], 1);
    check("t1_state_lo", st[0], 0);
    to_cyc(c + 7); check("t1_rel_pulse", rel[0], 0);

    // 2: three-cycle glitch is rejected
    step();
    btn[1] = 1'b1;
    c = cyc;
    repeat (3) step();
    btn[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      to_cyc(c + 3 + k);
      check("t2_state", st[1], 0);
      check("t2_valid", evt_if.evt_valid, 0);
    end

    // 3: simultaneous presses, stalled consumer, ascending drain
    step();
    evt_if.evt_ready = 1'b0;
    btn = 4'b1010;
    c = cyc;
    press_q.push_back('{1, c + 6});
    press_q.push_back('{3, c + 6});
    evt_q.push_back(1);
    evt_q.push_back(3);
    to_cyc(c + 8);
    check("t3_valid", evt_if.evt_valid, 1);
    check("t3_idx", evt_if.evt_idx, 1);
    for (int k = 1; k <= 20; k++) begin
      to_cyc(c + 8 + k);
      check("t3_hold_valid", evt_if.evt_valid, 1);
      check("t3_hold_idx", evt_if.evt_idx, 1);
    end
    step();
    evt_if.evt_ready = 1'b1;
    c = cyc;
    to_cyc(c);     check("t3_first", evt_if.evt_idx, 1);
    to_cyc(c + 1); check("t3_second_valid", evt_if.evt_valid, 1);
    check("t3_second", evt_if.evt_idx, 3);
    to_cyc(c + 2); check("t3_empty", evt_if.evt_valid, 0);
    check("t3_overflow", overflow, 0);
    step();
    evt_if.evt_ready = 1'b0;
    btn = '0;
    c = cyc;
    to_cyc(c + 7); check("t3_released", st, 0);

    // 4: second press while pending is dropped and flags overflow
    step();
    btn[2] = 1'b1;
    c = cyc;
    press_q.push_back('{2, c + 6});
    evt_q.push_back(2);
    to_cyc(c + 8);
    check("t4_valid", evt_if.evt_valid, 1);
    check("t4_idx", evt_if.evt_idx, 2);
    step();
    btn[2] = 1'b0;
    c = cyc;
    to_cyc(c + 6); check("t4_state_lo", st[2], 0);
    step();
    btn[2] = 1'b1;
    c = cyc;
    press_q.push_back('{2, c + 6});
    to_cyc(c + 6); check("t4_ovf_before", overflow, 0);
    to_cyc(c + 7); check("t4_ovf", overflow, 1);
    to_cyc(c + 10); check("t4_ovf_sticky", overflow, 1);
    check("t4_idx_held", evt_if.evt_idx, 2);
    step();
    evt_if.evt_ready = 1'b1;
    c = cyc;
    to_cyc(c);     check("t4_present", evt_if.evt_valid, 1);
    to_cyc(c + 1); check("t4_single_evt", evt_if.evt_valid, 0);
    to_cyc(c + 4); check("t4_no_more", evt_if.evt_valid, 0);
    check("t4_ovf_final", overflow, 1);
    step();
    evt_if.evt_ready = 1'b0;
    btn[2] = 1'b0;
    c = cyc;
    to_cyc(c + 7); check("t4_released", st, 0);

    // 5: reset during RISE_WAIT discards the count; re-debounce afterwards
    step();
    btn[0] = 1'b1;
    c = cyc;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    evt_if.evt_ready = 1'b1;
    c = cyc;
    press_q.push_back('{0, c + 6});
    evt_q.push_back(0);
    to_cyc(c);
    check("t5_state", st, 0);
    check("t5_press", press, 0);
    check("t5_release", rel, 0);
    check("t5_hold", hold, 0);
    check("t5_valid", evt_if.evt_valid, 0);
    check("t5_idx", evt_if.evt_idx, 0);
    check("t5_overflow", overflow, 0);
    to_cyc(c + 5); check("t5_state_early", st[0], 0);
    to_cyc(c + 6); check("t5_state_hi", st[0], 1);
    to_cyc(c + 8); check("t5_valid_evt", evt_if.evt_valid, 1);
    to_cyc(c + 9); check("t5_drained", evt_if.evt_valid, 0);
    step();
    btn[0] = 1'b0;
    c = cyc;
    to_cyc(c + 7); check("t5_released", st, 0);

    // 6: long press
    step();
    btn[3] = 1'b1;
    c = cyc;
    press_q.push_back('{3, c + 6});
    evt_q.push_back(3);
    to_cyc(c + 6); check("t6_state", st[3], 1);
`ifdef BUTTON_READER_HOLD_EN
    to_cyc(c + 13); check("t6_hold_early", hold[3], 0);
    to_cyc(c + 14); check("t6_hold", hold[3], 1);
    to_cyc(c + 20); check("t6_hold_kept", hold[3], 1);
`else
    to_cyc(c + 14); check("t6_hold_off", hold, 0);
    to_cyc(c + 20); check("t6_hold_off_late", hold, 0);
`endif
    step();
    btn[3] = 1'b0;
    c = cyc;
`ifdef BUTTON_READER_HOLD_EN
    to_cyc(c + 5); check("t6_hold_until_rel", hold[3], 1);
    check("t6_rel_early", rel[3], 0);
    to_cyc(c + 6); check("t6_hold_clr", hold[3], 0);
    check("t6_rel", rel[3], 1);
`else
    to_cyc(c + 6); check("t6_rel", rel[3], 1);
    check("t6_hold_off_rel", hold, 0);
`endif

    to_cyc(cyc + 3);
    check("press_q_empty", press_q.size(), 0);
    check("evt_q_empty", evt_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
